// File: rtl/pic_host_bus_master.sv
// Host-side bus initiator for an 8259A-style PIC: runs ICW/OCW writes, status reads
// and the two-pulse INTA cycle, driving the PIC pins from registered outputs.
module pic_host_bus_master #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       init_start,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       auto_ack_enable,
    input  logic       interrupt_to_cpu,
    output logic       interrupt_acknowledge_n,
    output logic       vector_valid,
    output logic [7:0] vector_data,
    output logic       chip_select_n,
    output logic       read_enable_n,
    output logic       write_enable_n,
    output logic       address,
    output logic [7:0] data_bus_out,
    output logic       data_bus_drive,
    input  logic [7:0] data_bus_in,
    output logic       busy
);

    localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [2:0]    STEP_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, HOLD, INTA1, INTA_GAP, INTA2, INTA_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          is_write;
    logic          init_active;
    logic [2:0]    step;
    logic [7:0]    icw_words [4];
    logic [2:0]    next_step_s;

    // Step after the current init word: ICW3 only in cascade mode, ICW4 only when requested.
    function automatic logic [2:0] next_init_step(input logic [2:0] cur, input logic [7:0] w1);
        logic [2:0] nxt;
        case (cur)
            3'd0:    nxt = 3'd1;
            3'd1:    nxt = (!w1[1]) ? 3'd2 : (w1[0] ? 3'd3 : STEP_DONE);
            3'd2:    nxt = w1[0] ? 3'd3 : STEP_DONE;
            default: nxt = STEP_DONE;
        endcase
        return nxt;
    endfunction

    assign next_step_s = next_init_step(step, icw_words[0]);
    assign busy        = (state != IDLE);

    // Single FSM: arbitration, bus-cycle sequencing and every pin-level output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                   <= IDLE;
            cnt                     <= '0;
            is_write                <= 1'b0;
            init_active             <= 1'b0;
            step                    <= 3'd0;
            icw_words[0]            <= 8'h00;
            icw_words[1]            <= 8'h00;
            icw_words[2]            <= 8'h00;
            icw_words[3]            <= 8'h00;
            cmd_ready               <= 1'b0;
            rsp_valid               <= 1'b0;
            rsp_data                <= 8'h00;
            vector_valid            <= 1'b0;
            vector_data             <= 8'h00;
            interrupt_acknowledge_n <= 1'b1;
            chip_select_n           <= 1'b1;
            read_enable_n           <= 1'b1;
            write_enable_n          <= 1'b1;
            address                 <= 1'b0;
            data_bus_out            <= 8'h00;
            data_bus_drive          <= 1'b0;
        end else begin
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            vector_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // A command already granted via cmd_ready is committed regardless of new requests.
                    if (cmd_ready) begin
                        address        <= cmd_a0;
                        is_write       <= cmd_write;
                        data_bus_out   <= cmd_write ? cmd_data : data_bus_out;
                        data_bus_drive <= cmd_write;
                        chip_select_n  <= 1'b0;
                        state          <= SETUP;
                    end else if (init_start) begin
                        icw_words[0]   <= icw1;
                        icw_words[1]   <= icw2;
                        icw_words[2]   <= icw3;
                        icw_words[3]   <= icw4;
                        init_active    <= 1'b1;
                        step           <= 3'd0;
                        is_write       <= 1'b1;
                        address        <= 1'b0;
                        data_bus_out   <= icw1;
                        data_bus_drive <= 1'b1;
                        chip_select_n  <= 1'b0;
                        state          <= SETUP;
                    end else if (auto_ack_enable && interrupt_to_cpu) begin
                        interrupt_acknowledge_n <= 1'b0;
                        cnt                     <= PULSE_LOAD;
                        state                   <= INTA1;
                    end else if (cmd_valid) begin
                        cmd_ready <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                SETUP: begin
                    cnt <= PULSE_LOAD;
                    if (is_write) begin
                        write_enable_n <= 1'b0;
                    end else begin
                        read_enable_n <= 1'b0;
                    end
                    state <= STROBE;
                end
                STROBE: begin
                    if (cnt == CNT_ONE) begin
                        write_enable_n <= 1'b1;
                        read_enable_n  <= 1'b1;
                        if (!is_write) begin
                            rsp_data  <= data_bus_in;
                            rsp_valid <= 1'b1;
                        end else begin
                            rsp_valid <= 1'b0;
                        end
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                HOLD: begin
                    // Init words run back to back with CS held low; busy only drops after the last one.
                    if (init_active && (next_step_s != STEP_DONE)) begin
                        step         <= next_step_s;
                        address      <= 1'b1;
                        data_bus_out <= icw_words[next_step_s[1:0]];
                        state        <= SETUP;
                    end else begin
                        init_active    <= 1'b0;
                        chip_select_n  <= 1'b1;
                        data_bus_drive <= 1'b0;
                        state          <= IDLE;
                    end
                end
                INTA1: begin
                    if (cnt == CNT_ONE) begin
                        interrupt_acknowledge_n <= 1'b1;
                        cnt                     <= GAP_LOAD;
                        state                   <= INTA_GAP;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                INTA_GAP: begin
                    if (cnt == CNT_ONE) begin
                        interrupt_acknowledge_n <= 1'b0;
                        cnt                     <= PULSE_LOAD;
                        state                   <= INTA2;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                INTA2: begin
                    if (cnt == CNT_ONE) begin
                        interrupt_acknowledge_n <= 1'b1;
                        vector_data             <= data_bus_in;
                        vector_valid            <= 1'b1;
                        state                   <= INTA_DONE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                INTA_DONE: begin
                    state <= IDLE;
                end
                default: begin
                    interrupt_acknowledge_n <= 1'b1;
                    read_enable_n           <= 1'b1;
                    write_enable_n          <= 1'b1;
                    chip_select_n           <= 1'b1;
                    data_bus_drive          <= 1'b0;
                    init_active             <= 1'b0;
                    state                   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pic_host_bus_master.sv
// Scoreboard bench for pic_host_bus_master: stimulus pushes expected bus events,
// a negedge monitor reconstructs strobe pulses and result pulses and pops/compares.
module tb_pic_host_bus_master;

    logic       clock = 1'b0;
    logic       reset;
    logic       init_start;
    logic [7:0] icw1, icw2, icw3, icw4;
    logic       cmd_valid, cmd_ready, cmd_write, cmd_a0;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       auto_ack_enable, interrupt_to_cpu, interrupt_acknowledge_n;
    logic       vector_valid;
    logic [7:0] vector_data;
    logic       chip_select_n, read_enable_n, write_enable_n, address;
    logic [7:0] data_bus_out;
    logic       data_bus_drive;
    logic [7:0] data_bus_in;
    logic       busy;

    pic_host_bus_master #(.PULSE_CYCLES(2), .GAP_CYCLES(1)) dut (
        .clock(clock), .reset(reset), .init_start(init_start),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_a0(cmd_a0), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .auto_ack_enable(auto_ack_enable), .interrupt_to_cpu(interrupt_to_cpu),
        .interrupt_acknowledge_n(interrupt_acknowledge_n),
        .vector_valid(vector_valid), .vector_data(vector_data),
        .chip_select_n(chip_select_n), .read_enable_n(read_enable_n),
        .write_enable_n(write_enable_n), .address(address),
        .data_bus_out(data_bus_out), .data_bus_drive(data_bus_drive),
        .data_bus_in(data_bus_in), .busy(busy)
    );

    always #5 clock = ~clock;

    localparam logic [2:0] K_WR = 3'd0, K_RD = 3'd1, K_INTA = 3'd2, K_RSP = 3'd3, K_VEC = 3'd4;

    typedef struct packed {
        logic [2:0] kind;
        logic       a0;
        logic [7:0] data;
        logic [3:0] width;
        logic       ok;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  passes = 0;

    function automatic ev_t mk(input logic [2:0] k, input logic a, input logic [7:0] d, input logic [3:0] w);
        ev_t e;
        e.kind = k; e.a0 = a; e.data = d; e.width = w; e.ok = 1'b1;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got === expv) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
    endtask

    task automatic check_ev(input ev_t got);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got %h expected none", got);
        end else begin
            e = exp_q.pop_front();
            if (got === e) passes++;
            else $display("FAIL event: got kind=%0d a0=%0d data=%h width=%0d ok=%0d expected kind=%0d a0=%0d data=%h width=%0d ok=%0d",
                          got.kind, got.a0, got.data, got.width, got.ok, e.kind, e.a0, e.data, e.width, e.ok);
        end
    endtask

    // Monitor: rebuild each strobe pulse (width, address, data, side-conditions) and result pulses.
    int         wr_run = 0, rd_run = 0, ia_run = 0;
    logic       wr_a0, rd_a0, wr_ok, rd_ok, ia_ok;
    logic [7:0] wr_d;
    always @(negedge clock) begin
        if (reset) begin
            wr_run = 0; rd_run = 0; ia_run = 0;
        end else begin
            if (!write_enable_n) begin
                if (wr_run == 0) begin wr_a0 = address; wr_d = data_bus_out; wr_ok = 1'b1; end
                wr_ok = wr_ok & !chip_select_n & data_bus_drive & read_enable_n & interrupt_acknowledge_n
                        & (address == wr_a0) & (data_bus_out == wr_d);
                wr_run++;
            end else if (wr_run > 0) begin
                check_ev({K_WR, wr_a0, wr_d, 4'(wr_run), wr_ok});
                wr_run = 0;
            end
            if (!read_enable_n) begin
                if (rd_run == 0) begin rd_a0 = address; rd_ok = 1'b1; end
                rd_ok = rd_ok & !chip_select_n & !data_bus_drive & write_enable_n & interrupt_acknowledge_n
                        & (address == rd_a0);
                rd_run++;
            end else if (rd_run > 0) begin
                check_ev({K_RD, rd_a0, 8'h00, 4'(rd_run), rd_ok});
                rd_run = 0;
            end
            if (!interrupt_acknowledge_n) begin
                if (ia_run == 0) ia_ok = 1'b1;
                ia_ok = ia_ok & chip_select_n & read_enable_n & write_enable_n;
                ia_run++;
            end else if (ia_run > 0) begin
                check_ev({K_INTA, 1'b0, 8'h00, 4'(ia_run), ia_ok});
                ia_run = 0;
            end
            if (rsp_valid)    check_ev({K_RSP, 1'b0, rsp_data, 4'd0, 1'b1});
            if (vector_valid) check_ev({K_VEC, 1'b0, vector_data, 4'd0, 1'b1});
        end
    end

    // Issue one register access; returns strobe/drive/rsp_valid patterns for cycles 1..5 after accept.
    task automatic bus_cmd(input logic w, input logic a, input logic [7:0] d,
                           output logic [4:0] sp, output logic [4:0] dp, output logic [4:0] rp);
        int n = 0;
        sp = 5'd0; dp = 5'd0; rp = 5'd0;
        cmd_write = w; cmd_a0 = a; cmd_data = d; cmd_valid = 1'b1;
        @(negedge clock);
        while (!cmd_ready && n < 50) begin n++; @(negedge clock); end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clock); #1 cmd_valid = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clock);
                sp = {sp[3:0], (w ? write_enable_n : read_enable_n)};
                dp = {dp[3:0], data_bus_drive};
                rp = {rp[3:0], rsp_valid};
            end
        end
    endtask

    // Follow one INTA cycle from its first low clock; optionally drop INT in the gap or pulse init_start.
    task automatic inta_seq(input logic drop_in_gap, input logic poke_init,
                            output logic [5:0] ip, output logic [5:0] vp, output logic saw_ready);
        int n = 0;
        ip = 6'd0; vp = 6'd0; saw_ready = 1'b0;
        @(negedge clock);
        while (interrupt_acknowledge_n && n < 30) begin n++; @(negedge clock); end
        if (interrupt_acknowledge_n) begin
            chk("inta_start_timeout", 32'd0, 32'd1);
            interrupt_to_cpu = 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (i > 0) @(negedge clock);
                ip = {ip[4:0], interrupt_acknowledge_n};
                vp = {vp[4:0], vector_valid};
                saw_ready = saw_ready | cmd_ready;
                if (i == 2 && drop_in_gap) interrupt_to_cpu = 1'b0;
                init_start = (i == 2) && poke_init;
                if (i == 5) interrupt_to_cpu = 1'b0;
            end
        end
    endtask

    task automatic do_init(input logic [7:0] w1, w2, w3, w4, input int exp_busy);
        int n = 0;
        icw1 = w1; icw2 = w2; icw3 = w3; icw4 = w4; init_start = 1'b1;
        @(negedge clock);
        init_start = 1'b0;
        while (busy && n < 100) begin n++; @(negedge clock); end
        chk("init_busy_cycles", 32'(n), 32'(exp_busy));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    logic [4:0] sp, dp, rp;
    logic [5:0] ip, vp;
    logic       saw;

    initial begin
        reset = 1'b1; init_start = 1'b0; icw1 = 8'h00; icw2 = 8'h00; icw3 = 8'h00; icw4 = 8'h00;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_a0 = 1'b0; cmd_data = 8'h00;
        auto_ack_enable = 1'b0; interrupt_to_cpu = 1'b0; data_bus_in = 8'h00;
        idle(2);
        chk("reset_strobes", {28'd0, interrupt_acknowledge_n, chip_select_n, read_enable_n, write_enable_n}, 32'hF);
        chk("reset_flags", {27'd0, busy, cmd_ready, rsp_valid, vector_valid, data_bus_drive}, 32'h0);
        chk("reset_data", {7'd0, address, rsp_data, vector_data, data_bus_out}, 32'h0);
        reset = 1'b0;
        idle(2);

        // ICW3 skipped (single mode), ICW4 issued
        exp_q.push_back(mk(K_WR, 1'b0, 8'h13, 4'd2));
        exp_q.push_back(mk(K_WR, 1'b1, 8'h20, 4'd2));
        exp_q.push_back(mk(K_WR, 1'b1, 8'h01, 4'd2));
        do_init(8'h13, 8'h20, 8'hAA, 8'h01, 12);
        idle(2);
        // cascade mode with ICW4: all four words
        exp_q.push_back(mk(K_WR, 1'b0, 8'h11, 4'd2));
        exp_q.push_back(mk(K_WR, 1'b1, 8'h08, 4'd2));
        exp_q.push_back(mk(K_WR, 1'b1, 8'h04, 4'd2));
        exp_q.push_back(mk(K_WR, 1'b1, 8'h01, 4'd2));
        do_init(8'h11, 8'h08, 8'h04, 8'h01, 16);
        idle(2);

        exp_q.push_back(mk(K_WR, 1'b1, 8'hFE, 4'd2));
        bus_cmd(1'b1, 1'b1, 8'hFE, sp, dp, rp);
        chk("write_wr_pattern", 32'(sp), 32'(5'b10011));
        chk("write_drive_pattern", 32'(dp), 32'(5'b11110));
        idle(1);
        data_bus_in = 8'h5A;
        exp_q.push_back(mk(K_RD, 1'b0, 8'h00, 4'd2));
        exp_q.push_back(mk(K_RSP, 1'b0, 8'h5A, 4'd0));
        bus_cmd(1'b0, 1'b0, 8'h00, sp, dp, rp);
        chk("read_rd_pattern", 32'(sp), 32'(5'b10011));
        chk("read_drive_pattern", 32'(dp), 32'(5'b00000));
        chk("read_rsp_pattern", 32'(rp), 32'(5'b00010));
        idle(2);

        data_bus_in = 8'h23; auto_ack_enable = 1'b1; interrupt_to_cpu = 1'b1;
        exp_q.push_back(mk(K_INTA, 1'b0, 8'h00, 4'd2));
        exp_q.push_back(mk(K_INTA, 1'b0, 8'h00, 4'd2));
        exp_q.push_back(mk(K_VEC, 1'b0, 8'h23, 4'd0));
        inta_seq(1'b0, 1'b0, ip, vp, saw);
        chk("inta_pattern", 32'(ip), 32'(6'b001001));
        chk("inta_vv_pattern", 32'(vp), 32'(6'b000001));
        idle(3);
        chk("no_retrigger_busy", 32'(busy), 32'd0);

        // INT drops during the gap: second pulse and vector still happen
        data_bus_in = 8'h31; interrupt_to_cpu = 1'b1;
        exp_q.push_back(mk(K_INTA, 1'b0, 8'h00, 4'd2));
        exp_q.push_back(mk(K_INTA, 1'b0, 8'h00, 4'd2));
        exp_q.push_back(mk(K_VEC, 1'b0, 8'h31, 4'd0));
        inta_seq(1'b1, 1'b0, ip, vp, saw);
        chk("gap_drop_inta_pattern", 32'(ip), 32'(6'b001001));
        chk("gap_drop_vv_pattern", 32'(vp), 32'(6'b000001));
        idle(3);

        // command and INT together: INTA wins, init_start during INTA ignored
        data_bus_in = 8'h47; interrupt_to_cpu = 1'b1;
        cmd_write = 1'b1; cmd_a0 = 1'b0; cmd_data = 8'hC3; cmd_valid = 1'b1;
        icw1 = 8'h13; icw2 = 8'h99;
        exp_q.push_back(mk(K_INTA, 1'b0, 8'h00, 4'd2));
        exp_q.push_back(mk(K_INTA, 1'b0, 8'h00, 4'd2));
        exp_q.push_back(mk(K_VEC, 1'b0, 8'h47, 4'd0));
        exp_q.push_back(mk(K_WR, 1'b0, 8'hC3, 4'd2));
        inta_seq(1'b0, 1'b1, ip, vp, saw);
        chk("ready_held_during_inta", 32'(saw), 32'd0);
        begin
            int n = 0;
            while (!cmd_ready && n < 20) begin n++; @(negedge clock); end
            chk("ready_after_inta", 32'(cmd_ready), 32'd1);
            @(posedge clock); #1 cmd_valid = 1'b0;
        end
        idle(8);

        // async reset in the middle of a WR strobe
        cmd_write = 1'b1; cmd_a0 = 1'b1; cmd_data = 8'h77; cmd_valid = 1'b1;
        begin
            int n = 0;
            while (write_enable_n && n < 20) begin n++; @(negedge clock); if (cmd_ready) begin @(posedge clock); #1 cmd_valid = 1'b0; end end
        end
        cmd_valid = 1'b0;
        chk("wr_reached_before_reset", 32'(write_enable_n), 32'd0);
        #2 reset = 1'b1;
        #1 chk("reset_mid_wr_strobes", {27'd0, busy, interrupt_acknowledge_n, chip_select_n, read_enable_n, write_enable_n}, 32'hF);
        idle(2);
        reset = 1'b0;
        idle(2);

        // async reset in the middle of INTA pulse 1
        interrupt_to_cpu = 1'b1;
        begin
            int n = 0;
            while (interrupt_acknowledge_n && n < 20) begin n++; @(negedge clock); end
        end
        #2 reset = 1'b1;
        #1 chk("reset_mid_inta_strobes", {27'd0, busy, interrupt_acknowledge_n, chip_select_n, read_enable_n, write_enable_n}, 32'hF);
        interrupt_to_cpu = 1'b0;
        idle(2);
        reset = 1'b0;
        idle(6);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
